spm_sram_responder: RTL and testbench
=====================================

SPM_SRAM_RESPONDER -- requirements
Module: spm_sram_responder

Interface
REQ-001 Param AddrWidth, 32, request address width in bits.
REQ-002 Param DataWidth, 32, data width in bits; multiple of 8.
REQ-003 Param StrbWidth, DataWidth/8, byte-strobe width.
REQ-004 Param NumWords, 256, storage depth in words; power of two, >= 2.
REQ-005 Param ReadLatency, 1, accept-to-rvalid cycles; legal range 1..4.
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 mem_valid_i  in  1  request valid.
REQ-009 mem_ready_o  out  1  request accept.
REQ-010 mem_addr_i  in  AddrWidth  byte address.
REQ-011 mem_wdata_i  in  DataWidth  write data.
REQ-012 mem_strb_i  in  StrbWidth  write byte enables.
REQ-013 mem_we_i  in  1  1 = write, 0 = read.
REQ-014 mem_rvalid_o  out  1  response valid.
REQ-015 mem_rdata_o  out  DataWidth  response data.
REQ-016 init_done_o  out  1  storage clearing complete.

Function
REQ-017 Handshake SHALL be: a request is accepted in a cycle with mem_valid_i && mem_ready_o; the master holds all request fields stable until acceptance.
REQ-018 Word index SHALL be mem_addr_i[log2(StrbWidth) +: log2(NumWords)]; lower byte-offset bits and upper bits are ignored, so addresses wrap modulo NumWords*StrbWidth.
REQ-019 FSM SHALL have states INIT and RUN; reset enters INIT.
REQ-020 In INIT a counter SHALL write zero to word 0..NumWords-1, one word per cycle, with mem_ready_o=0; after word NumWords-1 the FSM SHALL move to RUN on the next edge.
REQ-021 In RUN mem_ready_o SHALL be 1 continuously; init_done_o SHALL be 1 exactly in RUN.
REQ-022 An accepted write SHALL update only bytes whose strobe bit is 1; the update is visible to a read accepted in the following cycle.
REQ-023 Every accepted request, read or write, SHALL produce exactly one mem_rvalid_o pulse exactly ReadLatency cycles after acceptance, in acceptance order.
REQ-024 Read response data SHALL be the word content at acceptance time; write response data SHALL be all zeros.
REQ-025 Back-to-back requests SHALL be accepted every cycle in RUN; the latency pipeline holds up to ReadLatency in-flight responses with no stall.
REQ-026 A write with mem_strb_i=0 SHALL leave storage unchanged and still produce a response.
REQ-027 Outside an rvalid cycle, mem_rdata_o SHALL be zero.

Reset
REQ-028 On rst_ni low: FSM=INIT, init counter=0, mem_ready_o=0, init_done_o=0, mem_rvalid_o=0, mem_rdata_o=0, and the pipeline is emptied.
REQ-029 Reset mid-operation SHALL drop all in-flight responses and restart clearing from word 0.
REQ-030 Storage contents need no reset value; the INIT sweep defines them.

Configuration
REQ-031 Macro SPM_SRAM_RESPONDER_PARITY_EN: when defined, one even-parity bit per byte SHALL be stored, plus an output port mem_perr_o, 1 bit, reset 0.
REQ-032 With the macro, mem_perr_o SHALL pulse with mem_rvalid_o for a read when any stored byte parity mismatches; INIT writes correct parity for zero data.
REQ-033 Without the macro, no parity storage and no mem_perr_o port SHALL exist.

Structure
REQ-034 Package spm_sram_responder_pkg SHALL hold the FSM state enum and the MaxReadLatency=4 constant.
REQ-035 The latency pipeline SHALL be one sub-module, spm_resp_pipe (valid/data shift stages, parameter Depth).

Verification
REQ-036 Reset released -> mem_ready_o=0 for exactly 256 cycles; init_done_o=1 and ready=1 on the next cycle; a read of addr 0x3FC returns 0x00000000.
REQ-037 Write 0xDEADBEEF to 0x10 with strb=0xF, then a read of 0x10 the next cycle -> rvalid ReadLatency cycles after each request, in order; the read returns 0xDEADBEEF.
REQ-038 Write 0x11223344 to 0x20 with strb=0x5 over 0xAABBCCDD -> a read returns 0xAA22CC44.
REQ-039 Write 0x5A5A5A5A to 0x404 (NumWords=256) -> a read of 0x004 returns 0x5A5A5A5A (wrap).
REQ-040 Random stream of 1000 requests against a scoreboard, ReadLatency=1 and 4 -> one in-order response per request, zero mismatches.
REQ-041 Assert rst_ni for 1 cycle with 3 reads in flight -> no rvalid follows; init restarts with ready=0 for 256 cycles.

Source files
------------

// File: rtl/spm_sram_responder_pkg.sv
// Shared types and constants for the scratchpad SRAM responder.
package spm_sram_responder_pkg;

  localparam int MaxReadLatency = 4;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/spm_resp_pipe.sv
// Fixed-latency response pipeline: valid/data shift stages, Depth cycles deep.
module spm_resp_pipe #(
  parameter int Depth = 1,
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  // Data stages are zeroed whenever their valid is low, so the tail is clean between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= valid_i ? data_i : '0;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/spm_sram_responder.sv
// Scratchpad SRAM responder: clears storage after reset, then serves byte-strobed
// reads/writes with a fixed response latency. Optional macro SPM_SRAM_RESPONDER_PARITY_EN.
module spm_sram_responder
  import spm_sram_responder_pkg::*;
#(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int StrbWidth   = DataWidth / 8,
  parameter int NumWords    = 256,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic [DataWidth-1:0] mem_wdata_i,
  input  logic [StrbWidth-1:0] mem_strb_i,
  input  logic                 mem_we_i,
  output logic                 mem_rvalid_o,
  output logic [DataWidth-1:0] mem_rdata_o,
  output logic                 init_done_o
`ifdef SPM_SRAM_RESPONDER_PARITY_EN
  ,
  output logic                 mem_perr_o
`endif
);

  localparam int ByteOffW  = (StrbWidth > 1) ? $clog2(StrbWidth) : 0;
  localparam int IdxW      = $clog2(NumWords);
  localparam int PipeDepth = (ReadLatency > MaxReadLatency) ? MaxReadLatency :
                             (ReadLatency < 1) ? 1 : ReadLatency;

  state_e          state_q, state_d;
  logic [IdxW-1:0] initCnt_q, initCnt_d;
  logic            initWe;
  logic            accept;
  logic            acceptWr;
  logic [IdxW-1:0] wordIdx;
  logic            unusedAddr;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdWord;
  logic [DataWidth-1:0] respData;

  assign wordIdx    = mem_addr_i[ByteOffW +: IdxW];
  assign unusedAddr = ^mem_addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StInit;
      initCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    case (state_q)
      StInit: begin
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == IdxW'(NumWords - 1)) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    mem_ready_o = 1'b0;
    init_done_o = 1'b0;
    initWe      = 1'b0;
    case (state_q)
      StInit: initWe = 1'b1;
      StRun: begin
        mem_ready_o = 1'b1;
        init_done_o = 1'b1;
      end
      default: initWe = 1'b1;
    endcase
  end

  assign accept   = mem_valid_i & mem_ready_o;
  assign acceptWr = accept & mem_we_i;

  // The clearing sweep owns the write port until the FSM leaves INIT.
  always_ff @(posedge clk_i) begin
    if (initWe) begin
      mem_q[initCnt_q] <= '0;
    end else if (acceptWr) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (mem_strb_i[b]) begin
          mem_q[wordIdx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdWord   = mem_q[wordIdx];
  assign respData = mem_we_i ? '0 : rdWord;

`ifdef SPM_SRAM_RESPONDER_PARITY_EN
  logic [StrbWidth-1:0] par_q [NumWords];
  logic                 rdPerr;
  logic                 pipeValid;
  logic [DataWidth:0]   pipeData;

  always_ff @(posedge clk_i) begin
    if (initWe) begin
      par_q[initCnt_q] <= '0;
    end else if (acceptWr) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (mem_strb_i[b]) begin
          par_q[wordIdx][b] <= ^mem_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rdPerr = 1'b0;
    for (int b = 0; b < StrbWidth; b++) begin
      if ((^rdWord[b*8 +: 8]) != par_q[wordIdx][b]) begin
        rdPerr = 1'b1;
      end
    end
  end

  spm_resp_pipe #(
    .Depth(PipeDepth),
    .Width(DataWidth + 1)
  ) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(accept),
    .data_i ({rdPerr & ~mem_we_i, respData}),
    .valid_o(pipeValid),
    .data_o (pipeData)
  );

  assign mem_rvalid_o = pipeValid;
  assign mem_rdata_o  = pipeData[DataWidth-1:0];
  assign mem_perr_o   = pipeData[DataWidth];
`else
  spm_resp_pipe #(
    .Depth(PipeDepth),
    .Width(DataWidth)
  ) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(accept),
    .data_i (respData),
    .valid_o(mem_rvalid_o),
    .data_o (mem_rdata_o)
  );
`endif

endmodule

// File: tb/tb_spm_sram_responder.sv
// Scoreboard bench for spm_sram_responder: one stimulus stream drives a latency-1 and a
// latency-4 instance; each has its own expected queue drained by a negedge monitor.
module tb_spm_sram_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } expItem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        memValid = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] memWdata = '0;
  logic [3:0]  memStrb = '0;
  logic        memWe = 1'b0;

  logic        readyL1, rvalidL1, doneL1;
  logic [31:0] rdataL1;
  logic        readyL4, rvalidL4, doneL4;
  logic [31:0] rdataL4;
`ifdef SPM_SRAM_RESPONDER_PARITY_EN
  logic        perrL1, perrL4;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  expItem q1[$];
  expItem q4[$];
  expItem e1, e4;
  logic [31:0] modelMem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spm_sram_responder #(.ReadLatency(1)) dutL1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_valid_i (memValid),
    .mem_ready_o (readyL1),
    .mem_addr_i  (memAddr),
    .mem_wdata_i (memWdata),
    .mem_strb_i  (memStrb),
    .mem_we_i    (memWe),
    .mem_rvalid_o(rvalidL1),
    .mem_rdata_o (rdataL1),
    .init_done_o (doneL1)
`ifdef SPM_SRAM_RESPONDER_PARITY_EN
    ,
    .mem_perr_o  (perrL1)
`endif
  );

  spm_sram_responder #(.ReadLatency(4)) dutL4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_valid_i (memValid),
    .mem_ready_o (readyL4),
    .mem_addr_i  (memAddr),
    .mem_wdata_i (memWdata),
    .mem_strb_i  (memStrb),
    .mem_we_i    (memWe),
    .mem_rvalid_o(rvalidL4),
    .mem_rdata_o (rdataL4),
    .init_done_o (doneL4)
`ifdef SPM_SRAM_RESPONDER_PARITY_EN
    ,
    .mem_perr_o  (perrL4)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 256; i++) modelMem[i] = '0;
  endtask

  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [7:0] idx;
    idx = addr[9:2];
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) modelMem[idx][b*8 +: 8] = wdata[b*8 +: 8];
    end
  endtask

  // Issues one request accepted at the next posedge and queues its expected response.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] expData);
    expItem e;
    checkOutput("ready at issue L1", {31'b0, readyL1}, 32'd1);
    checkOutput("ready at issue L4", {31'b0, readyL4}, 32'd1);
    memValid = 1'b1;
    memWe    = we;
    memAddr  = addr;
    memWdata = wdata;
    memStrb  = strb;
    e.data   = we ? 32'h0 : expData;
    e.cyc    = cyc;
    q1.push_back(e);
    q4.push_back(e);
    if (we) modelWrite(addr, wdata, strb);
    @(posedge clk);
    #1;
    memValid = 1'b0;
    memWe    = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitInitDone(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (readyL1 == 1'b0 && readyL4 == 1'b0) n++;
      else break;
    end
    checkOutput({tag, " ready-low cycles"}, 32'(n), 32'd256);
    checkOutput({tag, " init_done L1"}, {31'b0, doneL1}, 32'd1);
    checkOutput({tag, " init_done L4"}, {31'b0, doneL4}, 32'd1);
    checkOutput({tag, " ready L1"}, {31'b0, readyL1}, 32'd1);
    checkOutput({tag, " ready L4"}, {31'b0, readyL4}, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (q1.size() == 0 && q4.size() == 0) break;
      @(negedge clk);
    end
    checkOutput({tag, " pending L1"}, 32'(q1.size()), 32'd0);
    checkOutput({tag, " pending L4"}, 32'(q4.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rvalidL1 === 1'b1) begin
      if (q1.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected rvalid L1: got data 0x%08h, expected no response (cycle %0d)", rdataL1, cyc);
      end else begin
        e1 = q1.pop_front();
        checkOutput("rdata L1", rdataL1, e1.data);
        checkOutput("latency L1", 32'(cyc - e1.cyc), 32'd1);
`ifdef SPM_SRAM_RESPONDER_PARITY_EN
        checkOutput("perr L1", {31'b0, perrL1}, 32'd0);
`endif
      end
    end else begin
      checkOutput("idle rdata L1", rdataL1, 32'h0);
    end
  end

  always @(negedge clk) begin
    if (rvalidL4 === 1'b1) begin
      if (q4.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected rvalid L4: got data 0x%08h, expected no response (cycle %0d)", rdataL4, cyc);
      end else begin
        e4 = q4.pop_front();
        checkOutput("rdata L4", rdataL4, e4.data);
        checkOutput("latency L4", 32'(cyc - e4.cyc), 32'd4);
`ifdef SPM_SRAM_RESPONDER_PARITY_EN
        checkOutput("perr L4", {31'b0, perrL4}, 32'd0);
`endif
      end
    end else begin
      checkOutput("idle rdata L4", rdataL4, 32'h0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        w;
    clearModel();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready L1", {31'b0, readyL1}, 32'd0);
    checkOutput("reset done L1", {31'b0, doneL1}, 32'd0);
    checkOutput("reset rvalid L4", {31'b0, rvalidL4}, 32'd0);
    checkOutput("reset done L4", {31'b0, doneL4}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitInitDone("init");

    applyStimulus(1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'h0000_0000);
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF, 32'h0);
    applyStimulus(1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hAA22_CC44);
    applyStimulus(1'b1, 32'h0000_0404, 32'h5A5A_5A5A, 4'hF, 32'h0);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h5A5A_5A5A);
    applyStimulus(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0013, 32'h0, 4'h0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0000_0010, 32'h0000_9900, 4'h2, 32'h0);
    idleCycle();
    applyStimulus(1'b0, 32'hFFFF_F010, 32'h0, 4'h0, 32'hDEAD_99EF);
    drain("directed");

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) begin
        idleCycle();
      end else begin
        w = 1'($urandom_range(1));
        a = $urandom();
        d = $urandom();
        s = 4'($urandom_range(15));
        applyStimulus(w, a, d, s, modelMem[a[9:2]]);
      end
    end
    drain("random");

    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, modelMem[8'h04]);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'h0, modelMem[8'h08]);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, modelMem[8'h01]);
    q1.delete();
    q4.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clearModel();
    waitInitDone("mid-op reset");

    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_0000);
    drain("post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
